// File: rtl/digrecon18_mr_if.sv
// Handshake bundle for the mixed-radix digit reconstructor.
// The producer/consumer side uses master and the reconstructor uses slave.
interface digrecon18_mr_if #(
  parameter int unsigned DIG_WIDTH = 18,
  parameter int unsigned OUT_WIDTH = 54
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DIG_WIDTH-1:0] in_digit;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [1:0]           out_count;
  logic                 out_err;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_err
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_err
  );
endinterface

// File: rtl/digrecon18_mr.sv
// Mixed-radix digit reconstructor: folds MSB-first digits of radix MODULUS into a binary value,
// one digit per cycle, and holds each frame result until the consumer takes it.
module digrecon18_mr #(
  parameter int unsigned MODULUS    = 177147,
  parameter int unsigned DIG_WIDTH  = 18,
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned OUT_WIDTH  = 54
) (
  input logic             clk,
  input logic             reset,
  digrecon18_mr_if.slave  bus
);

  localparam logic [OUT_WIDTH-1:0] ModW = OUT_WIDTH'(MODULUS);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e               state_q, state_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [1:0]           count_q, count_d;
  logic                 err_q, err_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]           out_count_q, out_count_d;
  logic                 out_err_q, out_err_d;

  logic [OUT_WIDTH-1:0] acc_step;
  logic [1:0]           count_step;
  logic                 digit_bad;
  logic                 at_max;
  logic                 err_step;

  // Product is taken modulo 2^OUT_WIDTH by the assignment width.
  assign acc_step   = (acc_q * ModW) + OUT_WIDTH'(bus.in_digit);
  assign count_step = count_q + 2'd1;
  assign digit_bad  = 64'(bus.in_digit) >= 64'(MODULUS);
  assign at_max     = (32'(count_q) + 32'd1) == MAX_DIGITS;
  assign err_step   = err_q | digit_bad;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      StAccum: begin
        if (bus.in_valid) begin
          if (bus.in_last || at_max) begin
            state_d     = StHold;
            out_data_d  = acc_step;
            out_count_d = count_step;
            // Reaching the digit limit without in_last is an overrun.
            out_err_d   = err_step | (at_max & ~bus.in_last);
            acc_d       = '0;
            count_d     = '0;
            err_d       = 1'b0;
          end else begin
            acc_d   = acc_step;
            count_d = count_step;
            err_d   = err_step;
          end
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StAccum;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = (state_q == StAccum) && !reset;
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_digrecon18_mr.sv
// Bench for digrecon18_mr: directed frames plus randomized traffic, checked against a
// frame-level reference model that evaluates each frame as a positional sum.
module tb_digrecon18_mr;

  localparam int unsigned Modulus   = 177147;
  localparam int unsigned DigWidth  = 18;
  localparam int unsigned MaxDigits = 3;
  localparam int unsigned OutWidth  = 54;

  logic clk;
  logic reset;

  digrecon18_mr_if #(.DIG_WIDTH(DigWidth), .OUT_WIDTH(OutWidth)) bus ();

  digrecon18_mr #(
    .MODULUS   (Modulus),
    .DIG_WIDTH (DigWidth),
    .MAX_DIGITS(MaxDigits),
    .OUT_WIDTH (OutWidth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Reference model state
  int unsigned       frame_q[$];
  logic              exp_valid;
  longint unsigned   exp_data;
  int unsigned       exp_count;
  logic              exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned frame_value(input int unsigned n);
    longint unsigned val = 0;
    for (int i = 0; i < int'(n); i++) begin
      longint unsigned pw = 1;
      for (int j = 0; j < int'(n) - 1 - i; j++) pw = pw * Modulus;
      val = val + longint'(frame_q[i]) * pw;
    end
    return val & ((64'd1 << OutWidth) - 64'd1);
  endfunction

  task automatic model_update(input logic rst, input logic v, input int unsigned d,
                              input logic l, input logic ordy);
    if (rst) begin
      frame_q.delete();
      exp_valid = 1'b0;
      exp_data  = 0;
      exp_count = 0;
      exp_err   = 1'b0;
    end else if (exp_valid) begin
      if (ordy) exp_valid = 1'b0;
    end else if (v) begin
      frame_q.push_back(d);
      if (l || frame_q.size() == MaxDigits) begin
        logic bad = 1'b0;
        foreach (frame_q[k]) if (frame_q[k] >= Modulus) bad = 1'b1;
        exp_data  = frame_value(frame_q.size());
        exp_count = frame_q.size();
        exp_err   = bad || (frame_q.size() == MaxDigits && !l);
        exp_valid = 1'b1;
        frame_q.delete();
      end
    end
  endtask

  // One clock cycle: check current outputs, drive new inputs, advance the model.
  task automatic step(input logic rst, input logic v, input int unsigned d,
                      input logic l, input logic ordy);
    @(negedge clk);
    check("in_ready",  64'(bus.in_ready),  64'(!exp_valid && !reset));
    check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    check("out_data",  64'(bus.out_data),  exp_data);
    check("out_count", 64'(bus.out_count), 64'(exp_count));
    check("out_err",   64'(bus.out_err),   64'(exp_err));
    reset         = rst;
    bus.in_valid  = v;
    bus.in_digit  = DigWidth'(d);
    bus.in_last   = l;
    bus.out_ready = ordy;
    model_update(rst, v, d, l, ordy);
  endtask

  task automatic after_edge_result(input string tag, input longint unsigned data,
                                   input int unsigned cnt, input logic err);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"},  64'(bus.out_data),  data);
    check({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
    check({tag, "_err"},   64'(bus.out_err),   64'(err));
  endtask

  initial begin
    longint unsigned v438;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_digit  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    model_update(1'b1, 1'b0, 0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Single digit frame
    step(0, 1, 5, 1, 1);
    after_edge_result("single5", 5, 1, 1'b0);
    step(0, 0, 0, 0, 1);

    // Three digits 1,0,2
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 2, 1, 1);
    after_edge_result("d102", 64'd31381059611, 3, 1'b0);
    step(0, 0, 0, 0, 1);

    // Largest legal digits
    step(0, 1, 177146, 0, 1);
    step(0, 1, 177146, 0, 1);
    step(0, 1, 177146, 1, 1);
    after_edge_result("dmax", 64'd5559060566555522, 3, 1'b0);
    step(0, 0, 0, 0, 1);

    // Out-of-range digit, then a clean frame
    step(0, 1, 177147, 1, 1);
    after_edge_result("bad", 64'd177147, 1, 1'b1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 3, 1, 1);
    after_edge_result("clean3", 3, 1, 1'b0);
    step(0, 0, 0, 0, 1);

    // Overrun: three digits without in_last
    v438 = 64'd4 * 64'd31381059609 + 64'd5 * 64'd177147 + 64'd6;
    step(0, 1, 4, 0, 1);
    step(0, 1, 5, 0, 1);
    step(0, 1, 6, 0, 1);
    after_edge_result("overrun", v438, 3, 1'b1);
    step(0, 0, 0, 0, 1);

    // Back-pressure: result held with out_ready low while digits are offered
    step(0, 1, 9, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 11 + i, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Reset mid-frame discards the partial frame
    step(0, 1, 1, 0, 1);
    step(0, 1, 2, 0, 1);
    step(1, 1, 3, 1, 1);
    step(0, 1, 7, 1, 1);
    after_edge_result("postrst", 7, 1, 1'b0);
    // Reset while a result is pending
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic        rv, rl, ro, rr;
      int unsigned rd;
      rr = ($urandom_range(0, 99) < 1);
      rv = ($urandom_range(0, 99) < 70);
      rl = ($urandom_range(0, 99) < 40);
      ro = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 9) == 0) rd = $urandom_range(Modulus, (1 << DigWidth) - 1);
      else                           rd = $urandom_range(0, Modulus - 1);
      step(rr, rv, rd, rl, ro);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/digrecon18_mr.md
DIGRECON18_MR -- requirements
Module: digrecon18_mr

Interface
REQ-001 The block SHALL have parameter MODULUS, default 177147, the digit radix (3^11).
REQ-002 The block SHALL have parameter DIG_WIDTH, default 18, the input digit width.
REQ-003 The block SHALL have parameter MAX_DIGITS, default 3, the maximum digits per frame.
REQ-004 The block SHALL have parameter OUT_WIDTH, default 54, the reconstructed value width; it must be at least ceil(log2(MODULUS^MAX_DIGITS)).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a digit is presented.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a digit this cycle.
REQ-009 The block SHALL have port in_digit, input, DIG_WIDTH bits: the mixed-radix digit, most significant first.
REQ-010 The block SHALL have port in_last, input, 1 bit: the presented digit is the final digit of the frame.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the reconstructed value is available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the value.
REQ-013 The block SHALL have port out_data, output, OUT_WIDTH bits: the reconstructed binary value.
REQ-014 The block SHALL have port out_count, output, 2 bits: the number of digits in the frame.
REQ-015 The block SHALL have port out_err, output, 1 bit: the frame contained a digit >= MODULUS, or the frame overran MAX_DIGITS.

Function
REQ-016 Handshake: a digit transfer SHALL occur when in_valid and in_ready are both high on a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-017 The FSM SHALL have two states, ACCUM and HOLD; in_ready SHALL be 1 in ACCUM and 0 in HOLD.
REQ-018 On each accepted digit, the accumulator SHALL update as acc <= (acc*MODULUS + in_digit) mod 2^OUT_WIDTH, and the digit count SHALL increment.
REQ-019 The first digit of a frame SHALL be computed with acc = 0.
REQ-020 An accepted digit >= MODULUS SHALL still be accumulated arithmetically and SHALL set a sticky frame error flag.
REQ-021 Frame close: an accepted digit with in_last=1, or the MAX_DIGITS-th accepted digit, SHALL close the frame.
REQ-022 On frame close, the next cycle SHALL present out_valid=1, out_data=final acc, out_count=digit count, and out_err=sticky flag; the FSM SHALL go to HOLD, and acc, count and flag SHALL clear.
REQ-023 If the MAX_DIGITS-th digit arrives with in_last=0, out_err SHALL be 1 (overrun); subsequent digits SHALL start a new frame.
REQ-024 Latency SHALL be one cycle from acceptance of the last digit to out_valid high.
REQ-025 Minimum frame period SHALL be (digits + 1) cycles when out_ready is tied high.
REQ-026 In HOLD, out_valid, out_data, out_count and out_err SHALL remain stable until an output transfer occurs.
REQ-027 On an output transfer, the FSM SHALL return to ACCUM, out_valid SHALL be 0 the next cycle, and in_ready SHALL be 1 the next cycle.
REQ-028 In ACCUM, a cycle with in_valid=0 SHALL leave acc and count unchanged; gaps between digits are legal.
REQ-029 out_data, out_count and out_err SHALL hold their last values when out_valid=0.

Reset
REQ-030 While reset=1 on a rising edge: state=ACCUM, acc=0, count=0, sticky flag=0, out_valid=0, out_data=0, out_count=0, out_err=0.
REQ-031 The first cycle after reset deasserts SHALL have in_ready=1.
REQ-032 Reset mid-frame or in HOLD SHALL discard the partial frame or the pending result; no output transfer for it SHALL occur.
REQ-033 in_ready SHALL be 0 while reset=1.

Verification
REQ-034 Single digit 5 with in_last=1 -> next cycle out_valid=1, out_data=5, out_count=1, out_err=0.
REQ-035 Digits 1, 0, 2 (last on 2) -> out_data=31381059611, out_count=3, out_err=0.
REQ-036 Digits 177146, 177146, 177146 (last on third) -> out_data=5559060566555522, out_err=0.
REQ-037 Digit 177147 with in_last=1 -> out_data=177147, out_err=1; a following frame with digit 3 and last=1 -> out_data=3, out_err=0.
REQ-038 Digits 4, 5, 6 with in_last=0 throughout -> after the third digit, out_valid=1, out_data=4*31381059609+5*177147+6, out_count=3, out_err=1.
REQ-039 out_ready held low 5 cycles -> out_* stable and in_ready=0 throughout; reset after 2 digits of a frame, then digit 7 with last=1 -> out_data=7, out_count=1.
